// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: pipeline instruction registers, scoreboard writeback
// and branch inputs, plus the stall/flush/forwarding decisions sent back to the core.
interface hazard_scoreboard_if #(
    parameter int Width = 32
);
    logic [Width-1:0] ir_FD;
    logic [Width-1:0] ir_EM;
    logic [Width-1:0] ir_MW;
    logic             reg_wrEM;
    logic             reg_wrMW;
    logic             rs1_used;
    logic             rs2_used;
    logic             long_op;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             br_taken;
    logic             stall;
    logic             flush;
    logic [1:0]       fora;
    logic [1:0]       forb;
    logic             err;

    modport master (
        output ir_FD, ir_EM, ir_MW, reg_wrEM, reg_wrMW, rs1_used, rs2_used,
        output long_op, wb_valid, wb_rd, br_taken,
        input  stall, flush, fora, forb, err
    );

    modport slave (
        input  ir_FD, ir_EM, ir_MW, reg_wrEM, reg_wrMW, rs1_used, rs2_used,
        input  long_op, wb_valid, wb_rd, br_taken,
        output stall, flush, fora, forb, err
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forward unit: EM/MW operand bypass, per-register pending scoreboard for
// long-latency ops, multi-cycle branch flush and a sticky writeback watchdog.
module hazard_scoreboard_unit #(
    parameter int Width      = 32,
    parameter int NumRegs    = 32,
    parameter int FlushDepth = 1,
    parameter int TimeoutCyc = 64
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave bus
);
    localparam int FcW = (FlushDepth < 1) ? 1 : $clog2(FlushDepth + 1);
    localparam int WdW = $clog2(TimeoutCyc + 1);

    logic [4:0] rs1, rs2, rd_fd, rd_em, rd_mw;
    assign rs1   = bus.ir_FD[19:15];
    assign rs2   = bus.ir_FD[24:20];
    assign rd_fd = bus.ir_FD[11:7];
    assign rd_em = bus.ir_EM[11:7];
    assign rd_mw = bus.ir_MW[11:7];

    // Opcode/funct bits are irrelevant to hazard detection.
    logic unused_bits;
    assign unused_bits = ^{bus.ir_FD[Width-1:25], bus.ir_FD[14:12], bus.ir_FD[6:0],
                           bus.ir_EM[Width-1:12], bus.ir_EM[6:0],
                           bus.ir_MW[Width-1:12], bus.ir_MW[6:0]};

    logic [NumRegs-1:0] pending_reg, pending_next;
    logic [FcW-1:0]     flush_cnt_reg;
    logic [WdW-1:0]     wdog_reg;
    logic               err_reg;
    logic               flush_int, stall_int, raw, waw, issue, wdog_count;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] em_rd,
                                           input logic em_wr, input logic [4:0] mw_rd,
                                           input logic mw_wr);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (em_wr && em_rd == rs)      sel = 2'b01;
            else if (mw_wr && mw_rd == rs) sel = 2'b10;
        end
        return sel;
    endfunction

    assign flush_int = bus.br_taken || (flush_cnt_reg != '0);
    assign raw       = (bus.rs1_used && pending_reg[rs1]) || (bus.rs2_used && pending_reg[rs2]);
    assign waw       = bus.long_op && pending_reg[rd_fd];
    assign stall_int = !flush_int && (raw || waw);
    assign issue     = bus.long_op && !stall_int && !flush_int && (rd_fd != 5'd0);

    // Set beats clear when the same register is issued and written back together.
    genvar gi;
    for (gi = 0; gi < NumRegs; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
        end else begin : g_reg
            assign pending_next[gi] = (issue && rd_fd == 5'(gi)) ||
                                      (pending_reg[gi] && !(bus.wb_valid && bus.wb_rd == 5'(gi)));
        end
    end

    assign wdog_count = (pending_reg != '0) && !bus.wb_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg   <= '0;
            flush_cnt_reg <= '0;
            wdog_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (bus.br_taken)
                flush_cnt_reg <= FcW'(FlushDepth);
            else if (flush_cnt_reg != '0)
                flush_cnt_reg <= flush_cnt_reg - FcW'(1);
            if (!wdog_count)
                wdog_reg <= '0;
            else if (wdog_reg != WdW'(TimeoutCyc))
                wdog_reg <= wdog_reg + WdW'(1);
            if (wdog_count && wdog_reg == WdW'(TimeoutCyc - 1))
                err_reg <= 1'b1;
        end
    end

    // Everything is held quiet while reset is asserted.
    assign bus.stall = !rst && stall_int;
    assign bus.flush = !rst && flush_int;
    assign bus.err   = !rst && err_reg;
    assign bus.fora  = rst ? 2'b00 : fwd_sel(rs1, rd_em, bus.reg_wrEM, rd_mw, bus.reg_wrMW);
    assign bus.forb  = rst ? 2'b00 : fwd_sel(rs2, rd_em, bus.reg_wrEM, rd_mw, bus.reg_wrMW);
endmodule
